sd_feed_ctrl: RTL and testbench

//  Sequencer in front of the 2nd-order sigma-delta modulator (sd_in port, BW bits).
//  - Accepts samples over valid/ready and presents one sample per OSR clocks.
//  - Applies a shift-based soft-start ramp and a soft-stop drain.
//  - Saturates samples to a stable-loop limit and flags underrun and clip events.

---
 rtl/sd_feed_ctrl_if.sv | 39 +++
 rtl/sd_feed_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sd_feed_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_feed_ctrl_if
// Description : Sample stream and modulator feed of sd_feed_ctrl.
//               s_data    signed input sample (BW bits)
//               s_valid   s_data valid
//               s_ready   controller can accept s_data
//               sd_in     signed sample presented to the modulator (BW bits)
//               sd_strobe high on the last clock of each sample period
//               master : sample source / modulator side
//               slave  : controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_feed_ctrl_if #(
  parameter int BW = 16
);
  logic signed [BW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [BW-1:0] sd_in;
  logic                 sd_strobe;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  sd_in,
    input  sd_strobe
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output sd_in,
    output sd_strobe
  );
endinterface
`default_nettype wire

// File: rtl/sd_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sd_feed_ctrl
// Description : Sequencer in front of a 2nd-order sigma-delta modulator.
//               Accepts samples over valid/ready, presents one sample every
//               OSR clocks, applies a shift-based soft-start ramp and a
//               soft-stop drain, saturates to +/-LIMIT and flags underrun
//               and clip events.
//               Ports: clk, rst_n (async, active low), enable (run/drain),
//               clr_flags (sync clear of flags), bus (sd_feed_ctrl_if.slave:
//               s_data/s_valid/s_ready, sd_in/sd_strobe), underrun, clip
//               (sticky flags), state (0 IDLE, 1 RAMP, 2 RUN, 3 DRAIN).
//               Optional: define SD_FEED_DITHER_EN to add +/-1 LFSR dither
//               to sd_in while in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_feed_ctrl #(
  parameter int BW         = 16,
  parameter int OSR        = 64,
  parameter int RAMP_SHIFT = 4,
  parameter int LIMIT      = 16384
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clr_flags,
  sd_feed_ctrl_if.slave bus,
  output logic          underrun,
  output logic          clip,
  output logic [1:0]    state
);

  localparam int c_CW = $clog2(OSR);
  localparam int c_SW = $clog2(RAMP_SHIFT + 1);
  localparam logic [c_CW-1:0]    c_CNT_MAX    = c_CW'(OSR - 1);
  localparam logic [c_SW-1:0]    c_SHIFT_INIT = c_SW'(RAMP_SHIFT);
  localparam logic [c_SW-1:0]    c_SHIFT_LAST = c_SW'(RAMP_SHIFT - 1);
  localparam logic signed [BW:0] c_LIM_P      = (BW+1)'(LIMIT);
  localparam logic signed [BW:0] c_LIM_N      = -c_LIM_P;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } t_state;

  t_state               r_state,   w_state_nx;
  logic [c_CW-1:0]      r_cnt,     w_cnt_nx;
  logic [c_SW-1:0]      r_shift,   w_shift_nx;
  logic signed [BW-1:0] r_cur,     w_cur_nx;
  logic signed [BW-1:0] r_nxt,     w_nxt_nx;
  logic                 r_nxt_v,   w_nxt_v_nx;
  logic                 r_underrun;
  logic                 r_clip;
  logic                 w_set_underrun;

  logic                 w_active;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_boundary;
  logic signed [BW-1:0] w_shifted;
  logic signed [BW:0]   w_ext;
  logic signed [BW:0]   w_dith;
  logic signed [BW:0]   w_pre;
  logic                 w_over_p;
  logic                 w_over_n;
  logic                 w_set_clip;
  logic signed [BW-1:0] w_sat;

  assign w_active   = (r_state == S_RAMP) || (r_state == S_RUN);
  assign w_ready    = !r_nxt_v && w_active;
  assign w_hs       = bus.s_valid && w_ready;
  assign w_boundary = (r_cnt == c_CNT_MAX) && (r_state != S_IDLE);

  // Output path: arithmetic shift, optional dither, then saturation done one
  // bit wider than the sample so the +/-LIMIT compare cannot wrap.
  assign w_shifted = r_cur >>> r_shift;
  assign w_ext     = {w_shifted[BW-1], w_shifted};

`ifdef SD_FEED_DITHER_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per sample period.
  logic [15:0] r_lfsr;
  logic        w_fb;
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_boundary) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  assign w_dith = (r_state != S_RUN) ? '0 :
                  (r_lfsr[0] ? (BW+1)'(1) : {(BW+1){1'b1}});
`else
  assign w_dith = '0;
`endif

  assign w_pre      = w_ext + w_dith;
  assign w_over_p   = w_pre > c_LIM_P;
  assign w_over_n   = w_pre < c_LIM_N;
  assign w_set_clip = (r_state != S_IDLE) && (w_over_p || w_over_n);
  assign w_sat      = w_over_p ? c_LIM_P[BW-1:0] :
                      w_over_n ? c_LIM_N[BW-1:0] : w_pre[BW-1:0];

  assign bus.sd_in     = (r_state == S_IDLE) ? '0 : w_sat;
  assign bus.sd_strobe = w_boundary;
  assign bus.s_ready   = w_ready;
  assign underrun      = r_underrun;
  assign clip          = r_clip;
  assign state         = r_state;

  // Next-state and datapath update.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_cur_nx       = r_cur;
    w_nxt_nx       = r_nxt;
    w_nxt_v_nx     = r_nxt_v;
    w_set_underrun = 1'b0;

    // A handshake normally parks the sample in nxt; the boundary bypass
    // below overrides this when nxt is empty on a boundary edge.
    if (w_hs) begin
      w_nxt_nx   = bus.s_data;
      w_nxt_v_nx = 1'b1;
    end

    if (r_state != S_IDLE) begin
      w_cnt_nx = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nx = S_RAMP;
          w_cnt_nx   = '0;
          w_shift_nx = c_SHIFT_INIT;
          w_cur_nx   = '0;
        end
      end
      S_RAMP, S_RUN: begin
        if (!enable) begin
          w_state_nx = S_DRAIN;
        end else if (w_boundary) begin
          if (r_nxt_v) begin
            w_cur_nx   = r_nxt;
            w_nxt_v_nx = 1'b0;
          end else if (w_hs) begin
            w_cur_nx   = bus.s_data;
            w_nxt_v_nx = 1'b0;
          end else begin
            w_set_underrun = 1'b1;
          end
          if (r_state == S_RAMP) begin
            // A ramp resumed from a fully drained-in DRAIN can hold shift 0.
            w_shift_nx = (r_shift == '0) ? '0 : r_shift - 1'b1;
            if (w_shift_nx == '0) begin
              w_state_nx = S_RUN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (enable) begin
          w_state_nx = S_RAMP;
        end else if (w_boundary) begin
          // The >= also covers a drain entered before the ramp began.
          if (r_shift >= c_SHIFT_LAST) begin
            w_state_nx = S_IDLE;
            w_shift_nx = c_SHIFT_INIT;
            w_cnt_nx   = '0;
            w_cur_nx   = '0;
            w_nxt_v_nx = 1'b0;
          end else begin
            w_shift_nx = r_shift + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= c_SHIFT_INIT;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_nxt_v    <= 1'b0;
      r_underrun <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_cur      <= w_cur_nx;
      r_nxt      <= w_nxt_nx;
      r_nxt_v    <= w_nxt_v_nx;
      // Set events take priority over a simultaneous clear.
      r_underrun <= w_set_underrun | (r_underrun & ~clr_flags);
      r_clip     <= w_set_clip | (r_clip & ~clr_flags);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_feed_ctrl
// Description : Directed self-checking bench for sd_feed_ctrl with
//               BW=16, OSR=4, RAMP_SHIFT=2, LIMIT=16384, dither off.
//               Expected sd_in values are queued when stimulus is driven and
//               popped when the DUT presents the corresponding sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_feed_ctrl;
  localparam int BW         = 16;
  localparam int OSR        = 4;
  localparam int RAMP_SHIFT = 2;
  localparam int LIMIT      = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clr_flags;
  logic       underrun;
  logic       clip;
  logic [1:0] state;

  sd_feed_ctrl_if #(.BW(BW)) bus ();

  sd_feed_ctrl #(
    .BW(BW), .OSR(OSR), .RAMP_SHIFT(RAMP_SHIFT), .LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_flags(clr_flags),
    .bus(bus), .underrun(underrun), .clip(clip), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] sb_q[$];

  function automatic logic [15:0] f_sat(input int v);
    if (v > LIMIT)  return 16'(LIMIT);
    if (v < -LIMIT) return 16'(-LIMIT);
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      timeout(tag);
    end else begin
      e = sb_q.pop_front();
      chk(tag, bus.sd_in, e);
    end
  endtask

  task automatic clk_chk(input string tag);
    @(posedge clk); #1;
    pop_chk(tag);
  endtask

  // Wait for the next boundary, then compare sd_in just after it.
  task automatic bnd_chk(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.sd_strobe && k < 3*OSR) begin
      @(negedge clk);
      k++;
    end
    if (!bus.sd_strobe) timeout({tag, "_strobe"});
    @(posedge clk); #1;
    pop_chk(tag);
  endtask

  // One handshake carrying d; queues the value the DUT should present in RUN.
  task automatic send(input logic [15:0] d);
    int k;
    k = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    sb_q.push_back(f_sat(int'($signed(d))));
    @(negedge clk);
    while (!bus.s_ready && k < 3*OSR) begin
      @(negedge clk);
      k++;
    end
    if (!bus.s_ready) timeout("send_ready");
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    rst_n       = 1'b0;
    enable      = 1'b0;
    clr_flags   = 1'b0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sd_in",    bus.sd_in,   16'h0000);
    chk("rst_s_ready",  {15'd0, bus.s_ready}, 16'h0000);
    chk("rst_state",    {14'd0, state}, 16'h0000);
    chk("rst_underrun", {15'd0, underrun}, 16'h0000);
    chk("rst_clip",     {15'd0, clip}, 16'h0000);
    rst_n = 1'b1;

    // Soft-start ramp with a continuous 0x2000 stream
    @(negedge clk);
    enable      = 1'b1;
    bus.s_data  = 16'h2000;
    bus.s_valid = 1'b1;
    repeat (4) sb_q.push_back(16'h0000);
    repeat (4) sb_q.push_back(16'h1000);
    repeat (4) sb_q.push_back(16'h2000);
    for (int i = 0; i < 12; i++) clk_chk("ramp_sd_in");
    chk("ramp_state_run", {14'd0, state}, 16'h0002);
    chk("ramp_no_underrun", {15'd0, underrun}, 16'h0000);
    bus.s_valid = 1'b0;

    // Saturation and clip (nxt still holds one 0x2000 from the stream)
    send(16'h7000);
    bnd_chk("sat_pos");
    tick();
    chk("clip_set", {15'd0, clip}, 16'h0001);
    send(16'h8000);
    bnd_chk("sat_neg");
    send(16'h0100);
    bnd_chk("in_range");
    chk("clip_sticky", {15'd0, clip}, 16'h0001);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clip_cleared", {15'd0, clip}, 16'h0000);
    chk("underrun_clear_before", {15'd0, underrun}, 16'h0000);

    // Underrun: no sample available at the next boundary
    sb_q.push_back(16'h0100);
    bnd_chk("underrun_hold");
    chk("underrun_set", {15'd0, underrun}, 16'h0001);
    tick();
    chk("underrun_sticky", {15'd0, underrun}, 16'h0001);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("underrun_cleared", {15'd0, underrun}, 16'h0000);

    // Bypass: sample offered only on the strobe cycle
    k = 0;
    @(negedge clk);
    while (!bus.sd_strobe && k < 3*OSR) begin
      @(negedge clk);
      k++;
    end
    if (!bus.sd_strobe) timeout("bypass_strobe");
    bus.s_data  = 16'h0200;
    bus.s_valid = 1'b1;
    sb_q.push_back(16'h0200);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    pop_chk("bypass_sd_in");
    chk("bypass_no_underrun", {15'd0, underrun}, 16'h0000);
    chk("bypass_nxt_empty", {15'd0, bus.s_ready}, 16'h0001);

    // Soft-stop drain from 0x2000
    send(16'h2000);
    bnd_chk("pre_drain");
    enable = 1'b0;
    tick();
    chk("drain_state", {14'd0, state}, 16'h0003);
    chk("drain_s_ready", {15'd0, bus.s_ready}, 16'h0000);
    sb_q.push_back(16'h1000);
    bnd_chk("drain_half");
    sb_q.push_back(16'h0000);
    bnd_chk("drain_zero");
    chk("drain_idle", {14'd0, state}, 16'h0000);
    chk("drain_no_underrun", {15'd0, underrun}, 16'h0000);

    // Restart with an initial gap (sets underrun), then async reset mid-RUN
    enable = 1'b1;
    repeat (6) tick();
    bus.s_data  = 16'h2000;
    bus.s_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(state == 2'd2 && bus.sd_in == 16'h2000) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!(state == 2'd2 && bus.sd_in == 16'h2000)) timeout("restart_run");
    chk("restart_underrun", {15'd0, underrun}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sd_in",    bus.sd_in, 16'h0000);
    chk("async_rst_s_ready",  {15'd0, bus.s_ready}, 16'h0000);
    chk("async_rst_state",    {14'd0, state}, 16'h0000);
    chk("async_rst_underrun", {15'd0, underrun}, 16'h0000);
    chk("async_rst_clip",     {15'd0, clip}, 16'h0000);
    bus.s_valid = 1'b0;
    enable      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
